// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and receiver state encodings
package uart_pkg;

    localparam int UART_DATA_BITS    = 8;
    localparam int UART_CLKS_PER_BIT = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_STARTCHK = 3'd1,
        ST_RXING    = 3'd2,
        ST_STOPCHK  = 3'd3,
        ST_WAITHIGH = 3'd4
    } rx_state_t;

endpackage

// File: rtl/rx_sync.sv
// rtl/rx_sync.sv - two-flop synchronizer with a configurable reset value
module rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver with mid-bit sampling, framing and overrun flags
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rxread,
    output logic [7:0] rxbyte,
    output logic       rxdone,
    output logic       rxavail,
    output logic       frameerr,
    output logic       overrun
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(UART_DATA_BITS);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(UART_DATA_BITS - 1);

    logic                      rx_s;
    rx_state_t                 state;
    logic [CNT_W-1:0]          cyc_cnt;
    logic [BIT_W-1:0]          bit_cnt;
    logic [UART_DATA_BITS-1:0] shreg;

    // Synchronizer resets to idle-high so a reset never looks like a start bit.
    rx_sync #(
        .RESET_VAL(1'b1)
    ) u_rx_sync (
        .clk(clk),
        .rst(rst),
        .d  (rx),
        .q  (rx_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cyc_cnt  <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            rxbyte   <= '0;
            rxdone   <= 1'b0;
            rxavail  <= 1'b0;
            frameerr <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            rxdone   <= 1'b0;
            frameerr <= 1'b0;
            if (rxread) begin
                rxavail <= 1'b0;
                overrun <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state   <= ST_STARTCHK;
                        cyc_cnt <= '0;
                        bit_cnt <= '0;
                    end
                end

                ST_STARTCHK: begin
                    if (cyc_cnt == HALF_LAST) begin
                        cyc_cnt <= '0;
                        state   <= rx_s ? ST_IDLE : ST_RXING;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end

                ST_RXING: begin
                    if (cyc_cnt == BIT_LAST) begin
                        cyc_cnt <= '0;
                        shreg   <= {rx_s, shreg[UART_DATA_BITS-1:1]};
                        if (bit_cnt == DATA_LAST) begin
                            state <= ST_STOPCHK;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end

                ST_STOPCHK: begin
                    if (cyc_cnt == BIT_LAST) begin
                        cyc_cnt <= '0;
                        if (rx_s) begin
                            // A read in the completion cycle acknowledges the old byte, not the new one.
                            rxbyte  <= shreg;
                            rxdone  <= 1'b1;
                            rxavail <= 1'b1;
                            overrun <= !rxread && (overrun || rxavail);
                            state   <= ST_IDLE;
                        end else begin
                            frameerr <= 1'b1;
                            state    <= ST_WAITHIGH;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end

                ST_WAITHIGH: begin
                    if (rx_s) begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
